// File: rtl/cache_pkg.sv
// Shared widths, array entry layout and controller states for the direct-mapped
// instruction cache.
package cache_pkg;

  localparam int unsigned TAG_W    = 20;
  localparam int unsigned INDEX_W  = 8;
  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned LINE_W   = 128;
  localparam int unsigned ENTRY_W  = 1 + TAG_W + LINE_W;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned BEAT_W   = 2;
  localparam int unsigned NUM_SETS = 1 << INDEX_W;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;
  } cache_entry_t;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    MISS,
    REFILL,
    WRITE,
    RESP
  } icache_state_t;

  // Word sel of a line; word k occupies bits 32k+31:32k.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [BEAT_W-1:0] sel);
    return line[{sel, 5'b00000} +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_ctrl.sv
// Blocking direct-mapped I-cache controller: clears the tag+data array after reset,
// serves hits at one fetch per cycle and refills a missing line as a 4-beat read.
module icache_ctrl
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               cpu_req,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic               cpu_addr_ok,
  output logic               cpu_data_ok,
  output logic [WORD_W-1:0]  cpu_rdata,
  output logic               mem_rd_req,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic               mem_rd_ack,
  input  logic               mem_rvalid,
  input  logic [WORD_W-1:0]  mem_rdata,
  input  logic               mem_rlast,
  output logic               bram_ena,
  output logic               bram_wea,
  output logic [INDEX_W-1:0] bram_addr,
  output logic [ENTRY_W-1:0] bram_din,
  input  logic [ENTRY_W-1:0] bram_dout
);

  icache_state_t      state_q, state_d;
  logic [INDEX_W-1:0] init_cnt_q;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] index_q;
  logic [BEAT_W-1:0]  word_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [LINE_W-1:0]  line_q;
  logic               accept;
  logic               hit;
  cache_entry_t       rd_entry;
  cache_entry_t       wr_entry;

  // Byte offset inside a word and the rlast marker carry no control information.
  logic unused_ok;
  assign unused_ok = ^{cpu_addr[1:0], mem_rlast};

  assign rd_entry = bram_dout;
  assign hit      = rd_entry.valid && (rd_entry.tag == tag_q);
  assign wr_entry = '{valid: 1'b1, tag: tag_q, line: line_q};

  // Next-state and array/bus outputs
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    cpu_addr_ok = 1'b0;
    cpu_data_ok = 1'b0;
    cpu_rdata   = '0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    bram_ena    = 1'b0;
    bram_wea    = 1'b0;
    bram_addr   = '0;
    bram_din    = '0;

    case (state_q)
      INIT: begin
        // Held inactive while resetn is low so the array sees no writes in reset.
        bram_ena  = resetn;
        bram_wea  = resetn;
        bram_addr = init_cnt_q;
        if (init_cnt_q == INDEX_W'(NUM_SETS - 1)) state_d = IDLE;
      end
      IDLE: begin
        cpu_addr_ok = 1'b1;
        bram_ena    = 1'b1;
        bram_addr   = cpu_addr[OFFSET_W +: INDEX_W];
        if (cpu_req) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          cpu_data_ok = 1'b1;
          cpu_rdata   = line_word(rd_entry.line, word_q);
          cpu_addr_ok = 1'b1;
          bram_ena    = 1'b1;
          bram_addr   = cpu_addr[OFFSET_W +: INDEX_W];
          accept      = cpu_req;
          state_d     = cpu_req ? LOOKUP : IDLE;
        end else begin
          state_d = MISS;
        end
      end
      MISS: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = {tag_q, index_q, OFFSET_W'(0)};
        if (mem_rd_ack) state_d = REFILL;
      end
      REFILL: begin
        if (mem_rvalid && (beat_q == BEAT_W'(3))) state_d = WRITE;
      end
      WRITE: begin
        bram_ena  = 1'b1;
        bram_wea  = 1'b1;
        bram_addr = index_q;
        bram_din  = wr_entry;
        state_d   = RESP;
      end
      RESP: begin
        cpu_data_ok = 1'b1;
        cpu_rdata   = line_word(line_q, word_q);
        state_d     = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // State, clear counter, request latch and line-fill buffer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      tag_q      <= '0;
      index_q    <= '0;
      word_q     <= '0;
      beat_q     <= '0;
      line_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_cnt_q <= init_cnt_q + 1'b1;
      if (accept) begin
        tag_q   <= cpu_addr[OFFSET_W + INDEX_W +: TAG_W];
        index_q <= cpu_addr[OFFSET_W +: INDEX_W];
        word_q  <= cpu_addr[2 +: BEAT_W];
      end
      if (state_q == MISS) beat_q <= '0;
      if ((state_q == REFILL) && mem_rvalid) begin
        line_q[{beat_q, 5'b00000} +: WORD_W] <= mem_rdata;
        beat_q <= beat_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: array and memory models plus a behavioural
// cache model (set tags only, data always equals backing memory).
module tb_icache_ctrl;
  import cache_pkg::*;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               cpu_req;
  logic [31:0]        cpu_addr;
  logic               cpu_addr_ok, cpu_data_ok;
  logic [31:0]        cpu_rdata;
  logic               mem_rd_req;
  logic [31:0]        mem_rd_addr;
  logic               mem_rd_ack, mem_rvalid, mem_rlast;
  logic [31:0]        mem_rdata;
  logic               bram_ena, bram_wea;
  logic [INDEX_W-1:0] bram_addr;
  logic [ENTRY_W-1:0] bram_din;
  logic [ENTRY_W-1:0] bram_dout = '0;

  icache_ctrl dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_addr_ok(cpu_addr_ok),
    .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk_i(input string nm, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endfunction

  function automatic void chk_w(input string nm, input logic [ENTRY_W-1:0] act,
                                input logic [ENTRY_W-1:0] want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endfunction

  // Backing memory contents, a pure function of the word address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a[31:4] == 28'h1FC0001) return 32'h1111_0000 | {28'h0, 2'b00, a[3:2]};
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  // Single-port array: 1-cycle read, write-first; powers up with stale valid lines.
  logic [ENTRY_W-1:0] arr [NUM_SETS];
  initial begin
    for (int i = 0; i < int'(NUM_SETS); i++)
      arr[i] = {1'b1, 20'h1FC00, $urandom, $urandom, $urandom, $urandom};
    forever begin
      @(posedge clk);
      if (bram_ena) begin
        if (bram_wea) begin
          arr[bram_addr] = bram_din;
          bram_dout <= bram_din;
        end else begin
          bram_dout <= arr[bram_addr];
        end
      end
    end
  end

  // Memory responder
  int          ack_dly = 0, gap_lo = 0, gap_hi = 0, beats_seen = 0;
  logic [31:0] last_req_addr = '0;
  initial begin
    logic [31:0] a;
    bit          abort;
    int          gp;
    mem_rd_ack = 0; mem_rvalid = 0; mem_rdata = 0; mem_rlast = 0;
    forever begin
      @(posedge clk); #1;
      if (resetn && mem_rd_req) begin
        a = mem_rd_addr; last_req_addr = a; beats_seen = 0; abort = 0;
        for (int w = 0; w < ack_dly; w++) begin
          @(posedge clk); #1;
          if (!resetn) begin abort = 1; break; end
          chk_i("mem_rd_addr_hold", int'(mem_rd_addr), int'(a));
          chk_i("mem_rd_req_hold", int'(mem_rd_req), 1);
        end
        if (!abort) begin
          mem_rd_ack = 1; @(posedge clk); #1; mem_rd_ack = 0;
          for (int k = 0; k < 4 && !abort; k++) begin
            gp = $urandom_range(gap_hi, gap_lo);
            for (int g = 0; g < gp; g++) begin @(posedge clk); #1; end
            if (!resetn) abort = 1;
            else begin
              mem_rvalid = 1; mem_rdata = word_of(a + 32'(4 * k)); mem_rlast = (k == 3);
              @(posedge clk); beats_seen++; #1;
              mem_rvalid = 0; mem_rlast = 0;
            end
          end
        end
      end
    end
  end

  // Behavioural model and per-cycle compare
  typedef struct { logic [31:0] data; bit hit; int acc; } exp_t;
  exp_t               exp_q[$];
  bit                 mvalid [NUM_SETS];
  logic [19:0]        mtag   [NUM_SETS];
  int                 cyc = 0, exp_miss = 0, act_miss = 0, last_beat = -100, last_acc = 0;
  bit                 prev_req = 0, in_refill = 0;
  logic [INDEX_W-1:0] last_wr_idx = '0;
  logic [ENTRY_W-1:0] last_wr_din = '0;
  logic [31:0]        resp_data[$];
  int                 resp_cyc[$];

  initial begin
    exp_t        e;
    logic [7:0]  idx;
    logic [19:0] tg;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        chk_i("reset_outputs_zero",
              int'({cpu_addr_ok, cpu_data_ok, mem_rd_req, bram_ena, bram_wea}), 0);
        exp_q.delete();
        for (int i = 0; i < int'(NUM_SETS); i++) mvalid[i] = 0;
        act_miss = 0; exp_miss = 0; prev_req = 0; in_refill = 0;
      end else begin
        if (mem_rd_req && !prev_req) act_miss++;
        prev_req = mem_rd_req;
        if (mem_rd_req) chk_i("bram_off_in_miss", int'(bram_ena), 0);
        if (mem_rd_req && mem_rd_ack) in_refill = 1;
        if (in_refill && bram_ena) chk_i("no_array_read_in_refill", int'(bram_wea), 1);
        if (mem_rvalid && mem_rlast) last_beat = cyc;
        if (bram_wea && bram_din[ENTRY_W-1]) begin
          last_wr_idx = bram_addr; last_wr_din = bram_din;
        end
        if (cpu_data_ok) begin
          in_refill = 0;
          if (exp_q.size() == 0) chk_i("spurious_data_ok", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk_i("rdata", int'(cpu_rdata), int'(e.data));
            chk_i("mem_fetch_count", act_miss, exp_miss);
            if (e.hit) chk_i("hit_latency", cyc - e.acc, 1);
            else       chk_i("miss_latency", cyc, last_beat + 2);
            resp_data.push_back(cpu_rdata);
            resp_cyc.push_back(cyc);
          end
        end
        if (cpu_req && cpu_addr_ok) begin
          chk_i("blocking_accept", exp_q.size(), 0);
          idx = cpu_addr[11:4]; tg = cpu_addr[31:12];
          e.data = word_of({cpu_addr[31:2], 2'b00});
          e.acc  = cyc;
          e.hit  = mvalid[idx] && (mtag[idx] == tg);
          if (!e.hit) exp_miss++;
          mvalid[idx] = 1; mtag[idx] = tg;
          last_acc = cyc;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Stimulus
  logic [31:0] pend[$];

  task automatic init_check();
    int t = 0;
    @(negedge clk);
    while (!bram_wea && t < 8) begin @(negedge clk); t++; end
    chk_i("init_start", int'(bram_wea), 1);
    for (int i = 0; i < int'(NUM_SETS); i++) begin
      chk_i("init_cycle", int'({bram_ena, bram_wea, cpu_addr_ok, (bram_din != '0), bram_addr}),
            'hC00 + i);
      @(negedge clk);
    end
    chk_i("init_done_addr_ok", int'(cpu_addr_ok), 1);
    chk_i("init_done_wea", int'(bram_wea), 0);
    @(posedge clk); #1;
  endtask

  task automatic accept_one(input logic [31:0] a);
    int t = 0;
    cpu_req = 1; cpu_addr = a;
    @(negedge clk);
    while (!cpu_addr_ok && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk_i("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cpu_req = 0; cpu_addr = $urandom;
  endtask

  task automatic issue();
    int t;
    while (pend.size() > 0) begin
      cpu_req = 1; cpu_addr = pend[0]; t = 0;
      @(negedge clk);
      while (!cpu_addr_ok && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) begin chk_i("accept_timeout", 0, 1); pend.delete(); end
      else void'(pend.pop_front());
      @(posedge clk); #1;
    end
    cpu_req = 0; cpu_addr = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 500) begin @(posedge clk); t++; end
    if (exp_q.size() > 0) chk_i("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int m0, t;
    logic [19:0] tags [4];
    logic [7:0]  idxs [4];
    tags[0] = 20'h1FC00; tags[1] = 20'h20000; tags[2] = 20'h00ABC; tags[3] = 20'hFFFFF;
    idxs[0] = 8'h00; idxs[1] = 8'h01; idxs[2] = 8'h02; idxs[3] = 8'hFF;
    cpu_req = 0; cpu_addr = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    init_check();

    // Cold miss with literal line contents
    pend.push_back(32'h1FC0_0014); issue(); drain();
    chk_i("t2_mem_addr", int'(last_req_addr), 32'h1FC0_0010);
    chk_i("t2_wr_idx", int'(last_wr_idx), 8'h01);
    chk_w("t2_wr_din", last_wr_din,
          {1'b1, 20'h1FC00, 128'h11110003_11110002_11110001_11110000});
    chk_i("t2_rdata", int'(resp_data[$]), 32'h1111_0001);
    chk_i("t2_resp_count", resp_data.size(), 1);
    chk_i("t2_latency", resp_cyc[$] - last_acc, 8);

    // Back-to-back hits
    m0 = act_miss;
    pend.push_back(32'h1FC0_0018); pend.push_back(32'h1FC0_001C); issue(); drain();
    chk_i("t3_rdata0", int'(resp_data[resp_data.size()-2]), 32'h1111_0002);
    chk_i("t3_rdata1", int'(resp_data[$]), 32'h1111_0003);
    chk_i("t3_consecutive", resp_cyc[$] - resp_cyc[resp_cyc.size()-2], 1);
    chk_i("t3_no_mem_req", act_miss, m0);

    // Conflict eviction
    m0 = act_miss;
    pend.push_back(32'h2000_0014); issue(); drain();
    chk_i("t4_conflict_idx", int'(last_wr_idx), 8'h01);
    pend.push_back(32'h1FC0_0014); issue(); drain();
    chk_i("t4_two_misses", act_miss - m0, 2);
    chk_i("t4_rdata", int'(resp_data[$]), 32'h1111_0001);

    // Slow ack and gapped beats
    ack_dly = 5; gap_lo = 2; gap_hi = 2;
    pend.push_back(32'h0000_4A28); issue(); drain();
    chk_i("t5_mem_addr", int'(last_req_addr), 32'h0000_4A20);
    chk_i("t5_latency", resp_cyc[$] - last_acc, 21);

    // Reset while waiting for ack: request must drop without a clock
    ack_dly = 6; gap_lo = 0; gap_hi = 0;
    accept_one(32'h0003_0040);
    t = 0;
    while (!mem_rd_req && t < 50) begin @(posedge clk); #2; t++; end
    chk_i("t6a_req_seen", int'(mem_rd_req), 1);
    resetn = 0; #1;
    chk_i("t6a_req_async_drop", int'(mem_rd_req), 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    init_check();

    // Reset after two refill beats discards the line
    ack_dly = 0; gap_lo = 1; gap_hi = 1; beats_seen = 0;
    accept_one(32'h0005_0084);
    t = 0;
    while (beats_seen < 2 && t < 100) begin @(posedge clk); #2; t++; end
    chk_i("t6b_two_beats", beats_seen, 2);
    resetn = 0; #1;
    chk_i("t6b_no_req", int'(mem_rd_req), 0);
    chk_i("t6b_no_data_ok", int'(cpu_data_ok), 0);
    repeat (4) @(posedge clk);
    #1 resetn = 1;
    init_check();
    m0 = act_miss;
    pend.push_back(32'h0005_0084); issue(); drain();
    chk_i("t6b_refetch_misses", act_miss - m0, 1);

    // Randomized traffic over a small conflicting address pool
    for (int b = 0; b < 60; b++) begin
      ack_dly = $urandom_range(3, 0); gap_lo = 0; gap_hi = $urandom_range(2, 0);
      for (int n = $urandom_range(4, 1); n > 0; n--)
        pend.push_back({tags[$urandom_range(3, 0)], idxs[$urandom_range(3, 0)],
                        2'($urandom), 2'($urandom)});
      issue(); drain();
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
